// File: rtl/scan_link_pkg.sv
// Shared scanner-link definitions: command codes, receiver states, and
// peer-status encodings used by both ends of the serial command link.
package scan_link_pkg;

  localparam logic [7:0] CMD_READY_XFER = 8'd2;
  localparam logic [7:0] CMD_START_SCAN = 8'd3;
  localparam logic [7:0] CMD_XFER       = 8'd4;
  localparam logic [7:0] CMD_DATA       = 8'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } rxState_t;

  typedef enum logic [1:0] {
    PEER_NONE       = 2'd0,
    PEER_NEAR_FULL  = 2'd1,
    PEER_START_SCAN = 2'd2,
    PEER_FULL       = 2'd3
  } peerState_t;

  // Maps a status command onto the peer-status field; non-status codes give NONE.
  function automatic peerState_t cmdToPeer(input logic [7:0] code);
    case (code)
      CMD_READY_XFER: return PEER_NEAR_FULL;
      CMD_START_SCAN: return PEER_START_SCAN;
      CMD_XFER:       return PEER_FULL;
      default:        return PEER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/scan_link_receiver_if.sv
// Serial link inputs and decoded command/status outputs of the scan link receiver.
// master = scanner/consumer side, slave = receiver side.
interface scan_link_receiver_if;
  logic       serClkIn;
  logic       serDataIn;
  logic       cmdValid;
  logic [7:0] cmdCode;
  logic       dataValid;
  logic [7:0] dataByte;
  logic [1:0] peerState;
  logic       frameErr;
  logic       busy;

  modport master (
    output serClkIn, serDataIn,
    input  cmdValid, cmdCode, dataValid, dataByte, peerState, frameErr, busy
  );

  modport slave (
    input  serClkIn, serDataIn,
    output cmdValid, cmdCode, dataValid, dataByte, peerState, frameErr, busy
  );
endinterface

// File: rtl/scan_shift_in.sv
// 8-bit LSB-first serial deserializer with a wrapping 3-bit bit counter.
// byteOut is the completed byte, valid in the cycle byteDone is high.
module scan_shift_in (
  input  logic       clk,
  input  logic       clear,
  input  logic       shiftEn,
  input  logic       bitIn,
  output logic [7:0] byteOut,
  output logic       byteDone
);

  logic [6:0] partial;
  logic [2:0] bitCount;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      bitCount <= '0;
    end else if (shiftEn) begin
      bitCount <= bitCount + 3'd1;
    end
  end

  // NOTE: the shift register is deliberately not reset; the bit counter alone
  // decides when its contents are meaningful, and 8 shifts overwrite it fully.
  always_ff @(posedge clk) begin
    if (shiftEn) begin
      partial <= {bitIn, partial[6:1]};
    end
  end

  // The 8th bit is taken straight from the input so the byte is decoded on its edge.
  assign byteOut  = {bitIn, partial};
  assign byteDone = shiftEn && (bitCount == 3'd7);

endmodule

// File: rtl/scan_link_receiver.sv
// Scan link receiver: reassembles command/payload frames from the scanner's serial
// link and decodes them into registered strobes and peer status. Optional mid-frame
// idle timeout is enabled by defining SCAN_RX_TIMEOUT_EN.
module scan_link_receiver
  import scan_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  scan_link_receiver_if.slave  link
);

  rxState_t   state, stateNext;
  peerState_t peerQ, peerNext;
  logic       cmdValidQ, cmdValidNext;
  logic       dataValidQ, dataValidNext;
  logic       frameErrQ, frameErrNext;
  logic [7:0] cmdCodeQ, cmdCodeNext;
  logic [7:0] dataByteQ, dataByteNext;
  logic [7:0] rxByte;
  logic       byteDone;
  logic       abort;

`ifdef SCAN_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idleCnt;

  always_ff @(posedge clk) begin
    if (!rst || state == ST_IDLE || link.serClkIn || abort) begin
      idleCnt <= '0;
    end else begin
      idleCnt <= idleCnt + IDLE_W'(1);
    end
  end

  assign abort = (state != ST_IDLE) && (idleCnt == IDLE_W'(TIMEOUT_CYCLES));
`else
  assign abort = 1'b0;
`endif

  // An abort discards the bit on its edge so the next frame starts clean.
  scan_shift_in u_shift (
    .clk      (clk),
    .clear    (!rst || abort),
    .shiftEn  (link.serClkIn && !abort),
    .bitIn    (link.serDataIn),
    .byteOut  (rxByte),
    .byteDone (byteDone)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statements can infer a latch.
  always_comb begin
    stateNext     = state;
    cmdValidNext  = 1'b0;
    dataValidNext = 1'b0;
    frameErrNext  = 1'b0;
    cmdCodeNext   = cmdCodeQ;
    dataByteNext  = dataByteQ;
    peerNext      = peerQ;

    if (abort) begin
      stateNext    = ST_IDLE;
      frameErrNext = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (link.serClkIn) stateNext = ST_CMD;
        end
        ST_CMD: begin
          if (byteDone) begin
            case (rxByte)
              CMD_READY_XFER, CMD_START_SCAN, CMD_XFER: begin
                cmdValidNext = 1'b1;
                cmdCodeNext  = rxByte;
                peerNext     = cmdToPeer(rxByte);
                stateNext    = ST_IDLE;
              end
              CMD_DATA: begin
                cmdValidNext = 1'b1;
                cmdCodeNext  = rxByte;
                stateNext    = ST_DATA;
              end
              default: begin
                frameErrNext = 1'b1;
                stateNext    = ST_IDLE;
              end
            endcase
          end
        end
        ST_DATA: begin
          if (byteDone) begin
            dataValidNext = 1'b1;
            dataByteNext  = rxByte;
            peerNext      = PEER_NONE;
            stateNext     = ST_IDLE;
          end
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cmdValidQ  <= 1'b0;
      dataValidQ <= 1'b0;
      frameErrQ  <= 1'b0;
      cmdCodeQ   <= '0;
      dataByteQ  <= '0;
      peerQ      <= PEER_NONE;
    end else begin
      state      <= stateNext;
      cmdValidQ  <= cmdValidNext;
      dataValidQ <= dataValidNext;
      frameErrQ  <= frameErrNext;
      cmdCodeQ   <= cmdCodeNext;
      dataByteQ  <= dataByteNext;
      peerQ      <= peerNext;
    end
  end

  assign link.cmdValid  = cmdValidQ;
  assign link.cmdCode   = cmdCodeQ;
  assign link.dataValid = dataValidQ;
  assign link.dataByte  = dataByteQ;
  assign link.peerState = peerQ;
  assign link.frameErr  = frameErrQ;
  assign link.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_scan_link_receiver.sv
// Self-checking bench for scan_link_receiver: a scoreboard of expected strobes is
// filled as frames are driven and drained by a monitor on the falling clock edge.
module tb_scan_link_receiver;

  localparam int KIND_CMD  = 0;
  localparam int KIND_DATA = 1;
  localparam int KIND_ERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic [7:0] dat;
    logic [1:0] peer;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   nChecks;
  int   nPass;
  exp_t q[$];

  logic [7:0] mCode;
  logic [7:0] mData;
  logic [1:0] mPeer;

  scan_link_receiver_if link ();

  scan_link_receiver #(.TIMEOUT_CYCLES(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", nChecks);
    $fatal(1, "watchdog expired");
  end

  // Model of the reference behaviour: legal codes and their peer status.
  function automatic void pushCmd(input logic [7:0] b, input int due);
    exp_t e;
    if (b == 8'd2 || b == 8'd3 || b == 8'd4) begin
      mCode = b;
      mPeer = (b == 8'd2) ? 2'd1 : (b == 8'd3) ? 2'd2 : 2'd3;
      e.kind = KIND_CMD;
    end else if (b == 8'd7) begin
      mCode = b;
      e.kind = KIND_CMD;
    end else begin
      e.kind = KIND_ERR;
    end
    e.code = mCode; e.dat = mData; e.peer = mPeer; e.due = due;
    q.push_back(e);
  endfunction

  function automatic void pushData(input logic [7:0] b, input int due);
    exp_t e;
    mData = b;
    mPeer = 2'd0;
    e.kind = KIND_DATA; e.code = mCode; e.dat = mData; e.peer = mPeer; e.due = due;
    q.push_back(e);
  endfunction

  function automatic void pushErr(input int due);
    exp_t e;
    e.kind = KIND_ERR; e.code = mCode; e.dat = mData; e.peer = mPeer; e.due = due;
    q.push_back(e);
  endfunction

  function automatic void modelReset();
    mCode = 8'd0;
    mData = 8'd0;
    mPeer = 2'd0;
  endfunction

  // Scoreboard monitor: outputs are sampled on the falling edge.
  int   monN;
  int   monKind;
  exp_t monE;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      monN = int'(link.cmdValid) + int'(link.dataValid) + int'(link.frameErr);
      if (monN > 0) begin
        nChecks++;
        if (monN == 1) nPass++;
        else $display("FAIL strobe_exclusive: cv=%b dv=%b fe=%b, want one-hot",
                      link.cmdValid, link.dataValid, link.frameErr);
        nChecks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_strobe: cv=%b dv=%b fe=%b at cycle %0d, want none",
                   link.cmdValid, link.dataValid, link.frameErr, cyc);
        end else begin
          nPass++;
          monE = q.pop_front();
          monKind = link.cmdValid ? KIND_CMD : link.dataValid ? KIND_DATA : KIND_ERR;
          nChecks++;
          if (monKind === monE.kind) nPass++;
          else $display("FAIL strobe_kind: got %0d, want %0d (0=cmd 1=data 2=err)", monKind, monE.kind);
          if (monE.due >= 0) begin
            nChecks++;
            if (cyc === monE.due) nPass++;
            else $display("FAIL strobe_latency: got cycle %0d, want cycle %0d", cyc, monE.due);
          end
          nChecks++;
          if (link.cmdCode === monE.code && link.dataByte === monE.dat && link.peerState === monE.peer)
            nPass++;
          else $display("FAIL strobe_fields: code=%h data=%h peer=%0d, want code=%h data=%h peer=%0d",
                        link.cmdCode, link.dataByte, link.peerState, monE.code, monE.dat, monE.peer);
        end
      end else if (q.size() > 0 && q[0].due >= 0 && cyc >= q[0].due) begin
        nChecks++;
        $display("FAIL missing_strobe: no strobe observed by cycle %0d, want kind %0d", cyc, q[0].kind);
        void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      link.serClkIn = 1'b0;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit isData, input int maxGap);
    for (int i = 0; i < 8; i++) begin
      if (maxGap > 0 && i > 0) idle($urandom_range(maxGap, 1));
      @(negedge clk);
      link.serClkIn  = 1'b1;
      link.serDataIn = b[i];
      if (i == 7) begin
        if (isData) pushData(b, cyc + 1);
        else pushCmd(b, cyc + 1);
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (q.size() == 0) nPass++;
    else begin
      $display("FAIL %s_drain: %0d strobes outstanding, want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    link.serClkIn  = 1'b0;
    link.serDataIn = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({link.cmdValid, link.dataValid, link.frameErr, link.busy} === 4'b0000) nPass++;
    else $display("FAIL reset_flags: cv=%b dv=%b fe=%b busy=%b, want 0000",
                  link.cmdValid, link.dataValid, link.frameErr, link.busy);
    nChecks++;
    if (link.cmdCode === 8'd0 && link.dataByte === 8'd0 && link.peerState === 2'd0) nPass++;
    else $display("FAIL reset_values: code=%h data=%h peer=%0d, want 0/0/0",
                  link.cmdCode, link.dataByte, link.peerState);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic test_cmd_ready();
    logic [7:0] b = 8'h02;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0 || i == 1) begin
        nChecks++;
        if (link.busy === (i == 1)) nPass++;
        else $display("FAIL cmd_ready_busy: got %b before bit %0d, want %b", link.busy, i, (i == 1));
      end
      link.serClkIn  = 1'b1;
      link.serDataIn = b[i];
      if (i == 7) pushCmd(b, cyc + 1);
    end
    idle(1);
    drain("cmd_ready", 4);
    nChecks++;
    if (link.peerState === 2'd1 && link.cmdCode === 8'd2 && link.busy === 1'b0) nPass++;
    else $display("FAIL cmd_ready_status: peer=%0d code=%h busy=%b, want 1/02/0",
                  link.peerState, link.cmdCode, link.busy);
  endtask

  task automatic test_back_to_back();
    sendByte(8'h07, 1'b0, 0);
    sendByte(8'hA5, 1'b1, 0);
    sendByte(8'h03, 1'b0, 0);
    idle(1);
    drain("back_to_back", 4);
    nChecks++;
    if (link.dataByte === 8'hA5 && link.cmdCode === 8'h03 && link.peerState === 2'd2) nPass++;
    else $display("FAIL back_to_back_status: data=%h code=%h peer=%0d, want A5/03/2",
                  link.dataByte, link.cmdCode, link.peerState);
  endtask

  task automatic test_gaps();
    sendByte(8'h07, 1'b0, 3);
    sendByte(8'h3C, 1'b1, 3);
    sendByte(8'h03, 1'b0, 3);
    idle(1);
    drain("gaps_cmd3", 4);
    nChecks++;
    if (link.peerState === 2'd2) nPass++;
    else $display("FAIL gaps_peer_after_3: got %0d, want 2", link.peerState);
    sendByte(8'h04, 1'b0, 3);
    idle(1);
    drain("gaps_cmd4", 4);
    nChecks++;
    if (link.peerState === 2'd3 && link.cmdCode === 8'h04) nPass++;
    else $display("FAIL gaps_peer_after_4: peer=%0d code=%h, want 3/04", link.peerState, link.cmdCode);
  endtask

  task automatic test_illegal();
    sendByte(8'h55, 1'b0, 0);
    @(negedge clk);
    link.serClkIn = 1'b0;
    nChecks++;
    if (link.busy === 1'b0 && link.cmdCode === 8'h04 && link.peerState === 2'd3) nPass++;
    else $display("FAIL illegal_status: busy=%b code=%h peer=%0d, want 0/04/3",
                  link.busy, link.cmdCode, link.peerState);
    drain("illegal", 4);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h04;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      link.serClkIn  = 1'b1;
      link.serDataIn = b[i];
    end
    @(negedge clk);
    link.serClkIn = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    nChecks++;
    if (link.busy === 1'b0 && link.cmdCode === 8'd0 && link.dataByte === 8'd0 && link.peerState === 2'd0)
      nPass++;
    else $display("FAIL reset_mid_values: busy=%b code=%h data=%h peer=%0d, want 0/00/00/0",
                  link.busy, link.cmdCode, link.dataByte, link.peerState);
    rst = 1'b1;
    modelReset();
    sendByte(8'h04, 1'b0, 0);
    idle(1);
    drain("reset_mid", 4);
    nChecks++;
    if (link.cmdCode === 8'h04 && link.peerState === 2'd3) nPass++;
    else $display("FAIL reset_mid_after: code=%h peer=%0d, want 04/3", link.cmdCode, link.peerState);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      link.serClkIn  = 1'b1;
      link.serDataIn = 1'b1;
    end
`ifdef SCAN_RX_TIMEOUT_EN
    pushErr(-1);
    idle(40);
    drain("timeout", 4);
    nChecks++;
    if (link.busy === 1'b0) nPass++;
    else $display("FAIL timeout_busy: got %b, want 0", link.busy);
`else
    idle(40);
    nChecks++;
    if (link.busy === 1'b1) nPass++;
    else $display("FAIL no_timeout_busy: got %b, want 1", link.busy);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
`endif
    sendByte(8'h02, 1'b0, 0);
    idle(1);
    drain("timeout_next", 4);
    nChecks++;
    if (link.cmdCode === 8'h02 && link.peerState === 2'd1) nPass++;
    else $display("FAIL timeout_next_cmd: code=%h peer=%0d, want 02/1", link.cmdCode, link.peerState);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst     = 1'b0;
    modelReset();
    test_reset();
    test_cmd_ready();
    test_back_to_back();
    test_gaps();
    test_illegal();
    test_reset_mid_frame();
    test_timeout();
    idle(4);
    nChecks++;
    if (q.size() == 0) nPass++;
    else $display("FAIL final_queue: %0d strobes outstanding, want 0", q.size());
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/scan_link_receiver.md
# scan_link_receiver

Receiving end of the scanner's serial command/data link. It samples the scanner's `clkOut`/`dataOut` pair in the system clock domain and reassembles 8-bit LSB-first command frames, plus the 8-bit payload that follows a DATA command. It decodes the command codes into registered strobes and a peer-status field for the downstream buffer controller. It sits between the scanner instance and the transfer/buffer manager.

## Interface
- `TIMEOUT_CYCLES`, default 32: number of idle `clk` cycles allowed mid-frame before the frame is aborted. Only used with the timeout feature.
- `clk  in  1`: system clock; all logic is on the posedge.
- `rst  in  1`: synchronous, active-low reset. 0 = reset.
- `serClkIn  in  1`: bit-valid qualifier, driven by the scanner `clkOut`. Sampled on `clk`.
- `serDataIn  in  1`: serial bit, driven by the scanner `dataOut`. Valid when `serClkIn`=1.
- `cmdValid  out  1`: one-cycle pulse when a legal command byte completes.
- `cmdCode  out  8`: last legal command byte. Held until the next legal command.
- `dataValid  out  1`: one-cycle pulse when a payload byte completes.
- `dataByte  out  8`: last payload byte. Held until the next payload.
- `peerState  out  2`: 0 = none, 1 = near-full (cmd 2), 2 = start-scan/90% (cmd 3), 3 = full (cmd 4).
- `frameErr  out  1`: one-cycle pulse on an illegal command code or on a timeout abort.
- `busy  out  1`: 1 whenever the state is not IDLE.

## Operation
- State machine has three states: IDLE, CMD, DATA. Reset state is IDLE.
- A bit is accepted on any `clk` edge where `serClkIn`=1. The bit is shifted in LSB first: bit n of the byte = nth accepted bit.
- IDLE: the first accepted bit is stored as bit 0. Move to CMD with bitCount=1.
- CMD: accept bits until bitCount wraps 7→0 (3-bit counter). On the 8th bit, decode the assembled byte:
  - 2, 3, 4: pulse `cmdValid`, load `cmdCode`, set `peerState` to 1/2/3 respectively. Go to IDLE.
  - 7: pulse `cmdValid`, load `cmdCode`=7, leave `peerState` unchanged. Go to DATA with bitCount=0.
  - Any other code: pulse `frameErr`. `cmdCode` and `peerState` are unchanged. Go to IDLE.
- DATA: accept 8 bits. On the 8th bit, pulse `dataValid`, load `dataByte`, clear `peerState` to 0. Go to IDLE.
- A bit accepted on the same edge a frame completes belongs to that frame. The next frame starts on the next accepted bit, so back-to-back frames need no gap.
- `cmdValid`, `dataValid` and `frameErr` are mutually exclusive in any cycle.
- Reset mid-frame: the partial byte is discarded. All outputs return to reset values on the next edge.

## Timing
- Reset values: `cmdValid`=0, `cmdCode`=0, `dataValid`=0, `dataByte`=0, `peerState`=0, `frameErr`=0, `busy`=0.
- Latency: strobes are registered. `cmdValid`/`dataValid`/`frameErr` are high in the cycle immediately after the edge that accepted the 8th bit. `cmdCode`/`dataByte` update on that same edge.
- Minimum frame: 8 consecutive cycles for a command, 16 for command plus payload.
- `busy` goes high the cycle after the first accepted bit. It goes low the cycle after frame completion or abort.
- There is no back-pressure. The consumer must take each strobe in its pulse cycle.
- `rst`=0 overrides all other activity on the same edge.

## Configuration
- `SCAN_RX_TIMEOUT_EN` defined:
  - An idle counter increments each cycle in CMD or DATA with `serClkIn`=0. It clears on every accepted bit and in IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`, go to IDLE, pulse `frameErr`, and discard the partial byte.
  - The counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter and no timeout abort. A partial frame waits indefinitely. `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `scan_link_pkg`, shared with the scanner:
  - `CMD_READY_XFER`=8'd2, `CMD_START_SCAN`=8'd3, `CMD_XFER`=8'd4, `CMD_DATA`=8'd7.
  - Receiver state enum (IDLE/CMD/DATA).
  - `peerState` encodings.
- Sub-module `scan_shift_in`: 8-bit LSB-first shift register with a 3-bit bit counter.
  - Inputs: shift-enable, clear.
  - Outputs: the byte and a byteDone flag.
- Decode and status logic stay in the top level.

## Test plan
- Send cmd 8'h02 as 8 bits (0,1,0,0,0,0,0,0) on consecutive cycles → `cmdValid` one cycle after the 8th bit, `cmdCode`=2, `peerState`=1.
- Send cmd 7 then payload 8'hA5 back-to-back → `cmdValid` with `cmdCode`=7, then `dataValid` 8 cycles later with `dataByte`=A5, `peerState`=0.
- Send cmd 3 then cmd 4 with `serClkIn` gaps of 1–3 cycles between bits → `peerState` goes 2 then 3, with no `frameErr`.
- Send illegal 8'h55 → `frameErr` pulse, no `cmdValid`, `cmdCode` and `peerState` unchanged, `busy`=0 next cycle.
- Send 4 bits of a command, then drive `rst`=0 for one cycle, then a full cmd 4 → no strobe from the partial frame, `cmdCode`=4 afterwards.
- With `SCAN_RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=32: send 5 bits, then idle 32 cycles → `frameErr` pulse, state IDLE, next full cmd 2 decodes correctly. Without the macro: no `frameErr` and `busy` stays 1.
